// File: rtl/writeback_unit_pkg.sv
// Shared constants, result record and arbitration selector for the writeback unit.
package writeback_unit_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int DATA_W        = 32;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int CNT_W         = 2;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] da;
        logic [DATA_W-1:0]     data;
    } wb_result_t;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_ALU    = 2'd1,
        SEL_FIFO   = 2'd2,
        SEL_BYPASS = 2'd3
    } wb_sel_e;

    // True when a decode read of ra must take the value being written this cycle.
    function automatic logic fwd_hit(input logic rw,
                                     input logic [REG_ADDR_W-1:0] da,
                                     input logic [REG_ADDR_W-1:0] ra);
        return rw && (da == ra) && (ra != ZERO_REG);
    endfunction

endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: two-entry in-order buffer for load results awaiting a register-file write slot.
module wb_fifo
    import writeback_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  wb_result_t       i_push_data,
    input  logic             i_pop,
    output wb_result_t       o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    wb_result_t       r_mem [WB_FIFO_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_W'(WB_FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU and load results onto the single register-file write port.
// Decode-side bypass of the write port is built only when WB_FORWARD_EN is defined.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_DA,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_DA,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  RW,
    output logic [REG_ADDR_W-1:0] DA,
    output logic [DATA_W-1:0]     D_Data,
    input  logic [REG_ADDR_W-1:0] AA,
    input  logic [REG_ADDR_W-1:0] BA,
    input  logic [DATA_W-1:0]     A_rf,
    input  logic [DATA_W-1:0]     B_rf,
    output logic [DATA_W-1:0]     A_Data,
    output logic [DATA_W-1:0]     B_Data,
    output logic [CNT_W-1:0]      pending
);

    // Handshake: a result moves on a channel only at a rising CLK edge where
    // valid and ready are both 1; ready never depends on valid.

    wb_result_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_alu_xfer;
    logic             w_mem_xfer;
    logic             w_push;
    logic             w_pop;
    wb_sel_e          w_sel;
    wb_result_t       w_sel_res;

    logic                  r_rw;
    logic [REG_ADDR_W-1:0] r_da;
    logic [DATA_W-1:0]     r_data;

    assign alu_ready  = !w_full;
    assign mem_ready  = !w_full;
    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_mem_xfer = mem_valid && mem_ready;
    assign pending    = w_count;

    wb_fifo u_fifo (
        .clk         (CLK),
        .rst_n       (reset),
        .i_push      (w_push),
        .i_push_data ({mem_DA, mem_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_comb begin
        w_sel     = SEL_NONE;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_sel_res = '0;
        if (w_full) begin
            // Both channels are stalled here, so draining the head cannot collide with a push.
            w_sel     = SEL_FIFO;
            w_pop     = 1'b1;
            w_sel_res = w_head;
        end else if (w_alu_xfer) begin
            w_sel     = SEL_ALU;
            w_push    = w_mem_xfer;
            w_sel_res = {alu_DA, alu_data};
        end else if (!w_empty) begin
            w_sel     = SEL_FIFO;
            w_pop     = 1'b1;
            w_push    = w_mem_xfer;
            w_sel_res = w_head;
        end else if (w_mem_xfer) begin
            w_sel     = SEL_BYPASS;
            w_sel_res = {mem_DA, mem_data};
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_rw   <= 1'b0;
            r_da   <= '0;
            r_data <= '0;
        end else begin
            // R0 results are consumed here but never reach the register file.
            r_rw <= (w_sel != SEL_NONE) && (w_sel_res.da != ZERO_REG);
            if (w_sel != SEL_NONE) begin
                r_da   <= w_sel_res.da;
                r_data <= w_sel_res.data;
            end
        end
    end

    assign RW     = r_rw;
    assign DA     = r_da;
    assign D_Data = r_data;

`ifdef WB_FORWARD_EN
    assign A_Data = fwd_hit(r_rw, r_da, AA) ? r_data : A_rf;
    assign B_Data = fwd_hit(r_rw, r_da, BA) ? r_data : B_rf;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{AA, BA};
    assign A_Data        = A_rf;
    assign B_Data        = B_rf;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed transfers, expected writes queued in order.
module tb_writeback_unit;

    localparam int W = 37;

    logic        CLK;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_DA;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_DA;
    logic [31:0] mem_data;
    logic        RW;
    logic [4:0]  DA;
    logic [31:0] D_Data;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic [31:0] A_rf;
    logic [31:0] B_rf;
    logic [31:0] A_Data;
    logic [31:0] B_Data;
    logic [1:0]  pending;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    writeback_unit dut (
        .CLK       (CLK),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_DA    (alu_DA),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_DA    (mem_DA),
        .mem_data  (mem_data),
        .RW        (RW),
        .DA        (DA),
        .D_Data    (D_Data),
        .AA        (AA),
        .BA        (BA),
        .A_rf      (A_rf),
        .B_rf      (B_rf),
        .A_Data    (A_Data),
        .B_Data    (B_Data),
        .pending   (pending)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] da, input logic [31:0] data);
        exp_q.push_back({da, data});
    endtask

    // Drives one cycle of channel inputs starting just after a rising edge,
    // then returns 1 time unit after the next rising edge with valids dropped.
    task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        alu_valid = av;
        alu_DA    = ad;
        alu_data  = adat;
        mem_valid = mv;
        mem_DA    = md;
        mem_data  = mdat;
        @(posedge CLK);
        #1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // monitor: every write on the port must match the head of the expected queue
    always @(negedge CLK) begin
        logic [W-1:0] e;
        if (reset && RW) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got DA=%0d D_Data=%0d, required no write", DA, D_Data);
            end else begin
                e = exp_q.pop_front();
                if ({DA, D_Data} !== e) begin
                    n_err++;
                    $display("FAIL write_order: got DA=%0d D_Data=%0d, required DA=%0d D_Data=%0d",
                             DA, D_Data, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] fwd_a;
        logic [31:0] fwd_b;
        reset     = 1'b0;
        alu_valid = 1'b0;
        alu_DA    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_DA    = '0;
        mem_data  = '0;
        AA        = '0;
        BA        = '0;
        A_rf      = '0;
        B_rf      = '0;

        #2;
        check("rst_rw", {31'd0, RW}, 32'd0);
        check("rst_da", {27'd0, DA}, 32'd0);
        check("rst_data", D_Data, 32'd0);
        check("rst_pending", {30'd0, pending}, 32'd0);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;

        // ALU only
        expect_wr(5'd4, 32'd100);
        step(1'b1, 5'd4, 32'd100, 1'b0, 5'd0, 32'd0);
        check("alu_rw", {31'd0, RW}, 32'd1);
        check("alu_da", {27'd0, DA}, 32'd4);
        idle();
        check("alu_rw_one_cycle", {31'd0, RW}, 32'd0);

        // same-cycle ALU and load
        expect_wr(5'd30, 32'd111);
        expect_wr(5'd31, 32'd123);
        step(1'b1, 5'd30, 32'd111, 1'b1, 5'd31, 32'd123);
        check("dual_pending1", {30'd0, pending}, 32'd1);
        idle();
        check("dual_pending0", {30'd0, pending}, 32'd0);
        idle();

        // ALU streaming while three loads arrive
        expect_wr(5'd1, 32'd201);
        expect_wr(5'd2, 32'd202);
        expect_wr(5'd10, 32'h1000);
        expect_wr(5'd3, 32'd203);
        expect_wr(5'd11, 32'h1100);
        expect_wr(5'd12, 32'h1200);
        step(1'b1, 5'd1, 32'd201, 1'b1, 5'd10, 32'h1000);
        step(1'b1, 5'd2, 32'd202, 1'b1, 5'd11, 32'h1100);
        check("full_pending", {30'd0, pending}, 32'd2);
        check("full_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("full_alu_ready", {31'd0, alu_ready}, 32'd0);
        step(1'b1, 5'd3, 32'd203, 1'b1, 5'd12, 32'h1200);
        check("drain_pending", {30'd0, pending}, 32'd1);
        check("drain_mem_ready", {31'd0, mem_ready}, 32'd1);
        step(1'b1, 5'd3, 32'd203, 1'b1, 5'd12, 32'h1200);
        check("refill_pending", {30'd0, pending}, 32'd2);
        idle();
        check("stream_pending1", {30'd0, pending}, 32'd1);
        idle();
        check("stream_pending0", {30'd0, pending}, 32'd0);
        idle();

        // simultaneous pop and push keeps order and occupancy
        expect_wr(5'd8, 32'd800);
        expect_wr(5'd13, 32'h1300);
        expect_wr(5'd14, 32'h1400);
        step(1'b1, 5'd8, 32'd800, 1'b1, 5'd13, 32'h1300);
        check("pp_pending_a", {30'd0, pending}, 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h1400);
        check("pp_pending_b", {30'd0, pending}, 32'd1);
        idle();
        check("pp_pending_c", {30'd0, pending}, 32'd0);
        idle();

        // R0 writes are consumed silently
        check("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step(1'b1, 5'd0, 32'd55, 1'b0, 5'd0, 32'd0);
        check("r0_alu_rw", {31'd0, RW}, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd77);
        check("r0_mem_rw", {31'd0, RW}, 32'd0);
        check("r0_mem_pending", {30'd0, pending}, 32'd0);

        // load bypass straight to the write port, then decode read path
        expect_wr(5'd31, 32'd123);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'd123);
        check("bypass_pending", {30'd0, pending}, 32'd0);
        check("bypass_rw", {31'd0, RW}, 32'd1);
        AA   = 5'd31;
        A_rf = 32'd0;
        BA   = 5'd0;
        B_rf = 32'd9;
        #1;
`ifdef WB_FORWARD_EN
        fwd_a = 32'd123;
        fwd_b = 32'd123;
`else
        fwd_a = 32'd0;
        fwd_b = 32'd5;
`endif
        check("fwd_a_hit", A_Data, fwd_a);
        check("fwd_b_r0", B_Data, 32'd9);
        BA   = 5'd31;
        B_rf = 32'd5;
        AA   = 5'd0;
        A_rf = 32'd42;
        #1;
        check("fwd_b_hit", B_Data, fwd_b);
        check("fwd_a_r0", A_Data, 32'd42);
        AA   = 5'd31;
        A_rf = 32'd0;
        idle();
        check("fwd_a_no_rw", A_Data, 32'd0);

        // reset with two loads buffered
        expect_wr(5'd6, 32'd600);
        step(1'b1, 5'd6, 32'd600, 1'b1, 5'd20, 32'd2000);
        step(1'b1, 5'd7, 32'd700, 1'b1, 5'd21, 32'd2100);
        check("prerst_pending", {30'd0, pending}, 32'd2);
        reset = 1'b0;
        #1;
        check("midrst_pending", {30'd0, pending}, 32'd0);
        check("midrst_rw", {31'd0, RW}, 32'd0);
        check("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        repeat (4) idle();
        check("postrst_pending", {30'd0, pending}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
